// File: rtl/chip8_pkg.sv
// rtl/chip8_pkg.sv - screen geometry and draw FSM state type for the CHIP-8 sprite drawer
package chip8_pkg;
    localparam int SCREEN_W = 64;
    localparam int SCREEN_H = 32;
    localparam int FB_BITS  = SCREEN_W * SCREEN_H;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAW,
        CLEAR
    } draw_state_t;
endpackage

// File: rtl/sprite_row_merge.sv
// rtl/sprite_row_merge.sv - XORs one sprite byte into a 64-pixel row, reporting any 1->0 pixel
module sprite_row_merge
    import chip8_pkg::*;
#(
    parameter bit WRAP_PIXELS = 1'b0
) (
    input  logic [SCREEN_W-1:0] row_in,
    input  logic [7:0]          sprite_byte,
    input  logic [5:0]          x0,
    output logic [SCREEN_W-1:0] row_out,
    output logic                hit
);
    logic [6:0] col [8];

    // bit 6 of the column marks a pixel that fell off the right edge
    for (genvar k = 0; k < 8; k++) begin : g_col
        assign col[k] = {1'b0, x0} + 7'(k);
    end

    always_comb begin
        row_out = row_in;
        hit     = 1'b0;
        for (int k = 0; k < 8; k++) begin
            if (sprite_byte[7-k] && (WRAP_PIXELS || !col[k][6])) begin
                row_out[col[k][5:0]] = ~row_in[col[k][5:0]];
                hit                  = hit | row_in[col[k][5:0]];
            end
        end
    end
endmodule

// File: rtl/sprite_drawer.sv
// rtl/sprite_drawer.sv - CHIP-8 DXYN sprite draw and 00E0 clear engine over a 64x32 framebuffer
module sprite_drawer
    import chip8_pkg::*;
#(
    parameter bit WRAP_PIXELS = 1'b0
) (
    input  logic               SYS_CLK,
    input  logic               SYS_RST_N,
    input  logic               start,
    input  logic               clear,
    input  logic [7:0]         x_coord,
    input  logic [7:0]         y_coord,
    input  logic [3:0]         n_rows,
    input  logic [11:0]        sprite_addr,
    output logic               mem_rd_en,
    output logic [11:0]        mem_addr,
    input  logic [7:0]         mem_rd_data,
    output logic [0:FB_BITS-1] flat_video_memory,
    output logic               busy,
    output logic               done,
    output logic               collision
);
    draw_state_t         state;
    logic [5:0]          x0;
    logic [4:0]          y0;
    logic [3:0]          n_lat;
    logic [3:0]          r;
    logic [11:0]         base;
    logic [4:0]          clr_row;
    logic [SCREEN_W-1:0] fb_rows [SCREEN_H];

    logic [5:0]          y_sum;
    logic [4:0]          row_sel;
    logic                row_ok;
    logic [SCREEN_W-1:0] merged_row;
    logic                row_hit;

    // y_sum[5] set means the row is below the screen; dropped unless wrapping
    assign y_sum   = {1'b0, y0} + {2'b00, r};
    assign row_sel = y_sum[4:0];
    assign row_ok  = WRAP_PIXELS || !y_sum[5];

    sprite_row_merge #(
        .WRAP_PIXELS(WRAP_PIXELS)
    ) u_merge (
        .row_in     (fb_rows[row_sel]),
        .sprite_byte(mem_rd_data),
        .x0         (x0),
        .row_out    (merged_row),
        .hit        (row_hit)
    );

    for (genvar rr = 0; rr < SCREEN_H; rr++) begin : g_row
        for (genvar cc = 0; cc < SCREEN_W; cc++) begin : g_col
            assign flat_video_memory[rr*SCREEN_W + cc] = fb_rows[rr][cc];
        end
    end

    always_ff @(posedge SYS_CLK or negedge SYS_RST_N) begin
        if (!SYS_RST_N) begin
            state     <= IDLE;
            x0        <= '0;
            y0        <= '0;
            n_lat     <= '0;
            r         <= '0;
            base      <= '0;
            clr_row   <= '0;
            mem_rd_en <= 1'b0;
            mem_addr  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            collision <= 1'b0;
            for (int i = 0; i < SCREEN_H; i++) begin
                fb_rows[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state     <= CLEAR;
                        clr_row   <= '0;
                        collision <= 1'b0;
                        busy      <= 1'b1;
                    end else if (start) begin
                        x0        <= 6'(x_coord % 8'(SCREEN_W));
                        y0        <= 5'(y_coord % 8'(SCREEN_H));
                        n_lat     <= n_rows;
                        base      <= sprite_addr;
                        r         <= '0;
                        collision <= 1'b0;
                        if (n_rows == 4'd0) begin
                            done <= 1'b1;
                        end else begin
                            state     <= FETCH;
                            busy      <= 1'b1;
                            mem_rd_en <= 1'b1;
                            mem_addr  <= sprite_addr;
                        end
                    end
                end
                FETCH: begin
                    mem_rd_en <= 1'b0;
                    state     <= DRAW;
                end
                DRAW: begin
                    if (row_ok) begin
                        fb_rows[row_sel] <= merged_row;
                        if (row_hit) begin
                            collision <= 1'b1;
                        end
                    end
                    if (r == n_lat - 4'd1) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        r         <= r + 4'd1;
                        state     <= FETCH;
                        mem_rd_en <= 1'b1;
                        mem_addr  <= base + 12'(r + 4'd1);
                    end
                end
                CLEAR: begin
                    fb_rows[clr_row] <= '0;
                    if (clr_row == 5'(SCREEN_H - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        clr_row <= clr_row + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
